// File: rtl/ss_scan_driver_if.sv
// rtl/ss_scan_driver_if.sv - digit data/control inputs and segment/anode pins of the scan driver
interface ss_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] Din;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    load;
  logic                    lz_en;
  logic [NUM_DIGITS-1:0]   blink_mask;
  logic                    a, b, c, d, e, f, g;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_tick;

  modport master (
    output Din, dp_in, load, lz_en, blink_mask,
    input  a, b, c, d, e, f, g, dp, an, frame_tick
  );

  modport slave (
    input  Din, dp_in, load, lz_en, blink_mask,
    output a, b, c, d, e, f, g, dp, an, frame_tick
  );
endinterface

// File: rtl/ss_scan_driver.sv
// rtl/ss_scan_driver.sv - multiplexed seven-segment driver with frame-synchronous load, zero blanking and blink
module ss_scan_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 100000,
  parameter int BLINK_FRAMES   = 64,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  ss_scan_driver_if.slave   sd
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);
  localparam logic [6:0]            SEG_OFF = {7{SEG_ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{AN_ACTIVE_LOW}};

  logic [SW-1:0]           scan_cnt;
  logic [IW-1:0]           idx;
  logic [FW-1:0]           frame_cnt;
  logic                    phase;
  logic [4*NUM_DIGITS-1:0] pending, shadow;
  logic [NUM_DIGITS-1:0]   pending_dp, shadow_dp;
  logic                    pending_valid;
  logic [NUM_DIGITS-1:0]   blink_lat;

  logic [6:0]              seg_q;
  logic                    dp_q;
  logic [NUM_DIGITS-1:0]   an_q;
  logic                    frame_tick_q;

  logic                    scan_wrap, frame_wrap;
  logic [3:0]              nib;
  logic                    dp_cur, blink_cur, lz_cur, lit, nz_seen;
  logic [NUM_DIGITS-1:0]   lz_blank, an_oh;
  logic [6:0]              seg_log;
  logic                    dp_log;
  logic [NUM_DIGITS-1:0]   an_log;

  // Logical active-high {a,b,c,d,e,f,g}
  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    case (v)
      4'h0: seg_decode = 7'b1111110;
      4'h1: seg_decode = 7'b0110000;
      4'h2: seg_decode = 7'b1101101;
      4'h3: seg_decode = 7'b1111001;
      4'h4: seg_decode = 7'b0110011;
      4'h5: seg_decode = 7'b1011011;
      4'h6: seg_decode = 7'b1011111;
      4'h7: seg_decode = 7'b1110000;
      4'h8: seg_decode = 7'b1111111;
      4'h9: seg_decode = 7'b1111011;
      4'hA: seg_decode = 7'b1110111;
      4'hB: seg_decode = 7'b0011111;
      4'hC: seg_decode = 7'b1001110;
      4'hD: seg_decode = 7'b0111101;
      4'hE: seg_decode = 7'b1001111;
      default: seg_decode = 7'b1000111;
    endcase
  endfunction

  assign scan_wrap  = (scan_cnt == SCAN_LAST);
  assign frame_wrap = scan_wrap && (idx == IDX_LAST);

  always_comb begin
    nib       = 4'h0;
    dp_cur    = 1'b0;
    blink_cur = 1'b0;
    lz_cur    = 1'b0;
    an_oh     = '0;
    lz_blank  = '0;
    nz_seen   = 1'b0;
    // Blanking runs from the most significant digit down; digit 0 is never blanked
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      nz_seen     = nz_seen | (shadow[4*i +: 4] != 4'h0);
      lz_blank[i] = sd.lz_en & ~nz_seen;
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        nib       = shadow[4*i +: 4];
        dp_cur    = shadow_dp[i];
        blink_cur = blink_lat[i];
        lz_cur    = lz_blank[i];
        an_oh[i]  = 1'b1;
      end
    end
    lit     = ~(phase & blink_cur);
    seg_log = (lit && !lz_cur) ? seg_decode(nib) : 7'b0000000;
    dp_log  = lit & dp_cur;
    an_log  = lit ? an_oh : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt      <= '0;
      idx           <= '0;
      frame_cnt     <= '0;
      phase         <= 1'b0;
      pending       <= '0;
      pending_dp    <= '0;
      pending_valid <= 1'b0;
      shadow        <= '0;
      shadow_dp     <= '0;
      blink_lat     <= '0;
      seg_q         <= SEG_OFF;
      dp_q          <= SEG_ACTIVE_LOW;
      an_q          <= AN_OFF;
      frame_tick_q  <= 1'b0;
    end else begin
      seg_q        <= seg_log ^ SEG_OFF;
      dp_q         <= dp_log ^ SEG_ACTIVE_LOW;
      an_q         <= an_log ^ AN_OFF;
      frame_tick_q <= frame_wrap;

      if (scan_wrap) begin
        scan_cnt  <= '0;
        // Mask is sampled once per slot so a digit never flickers mid-slot
        blink_lat <= sd.blink_mask;
        idx       <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end

      if (frame_wrap) begin
        if (frame_cnt == FRAME_LAST) begin
          frame_cnt <= '0;
          phase     <= ~phase;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
        pending_valid <= 1'b0;
        if (sd.load) begin
          shadow    <= sd.Din;
          shadow_dp <= sd.dp_in;
        end else if (pending_valid) begin
          shadow    <= pending;
          shadow_dp <= pending_dp;
        end
      end else if (sd.load) begin
        pending       <= sd.Din;
        pending_dp    <= sd.dp_in;
        pending_valid <= 1'b1;
      end
    end
  end

  assign sd.a          = seg_q[6];
  assign sd.b          = seg_q[5];
  assign sd.c          = seg_q[4];
  assign sd.d          = seg_q[3];
  assign sd.e          = seg_q[2];
  assign sd.f          = seg_q[1];
  assign sd.g          = seg_q[0];
  assign sd.dp         = dp_q;
  assign sd.an         = an_q;
  assign sd.frame_tick = frame_tick_q;

endmodule

// File: doc/ss_scan_driver.md
Name: ss_scan_driver

Overview:
- Parametrised multi-digit seven-segment display driver.
- Time-multiplexes NUM_DIGITS hex digits onto one shared a–g/dp segment bus with per-digit anode enables.
- Adds three features on top of the single-digit decoder:
  - frame-synchronous value loading, so a digit change never shows a half-old/half-new value;
  - leading-zero suppression;
  - per-digit blinking.
- Sits between the game score/state logic and the board display pins.

Parameters:
- NUM_DIGITS, 4: number of digits scanned, 1..8.
- SCAN_DIV, 100000: clk cycles each digit stays lit, >=2.
- BLINK_FRAMES, 64: full scan frames per blink half-period, >=1.
- SEG_ACTIVE_LOW, 1: 1 = segment pins driven low-true.
- AN_ACTIVE_LOW, 1: 1 = anode pins driven low-true.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- Din  input  4*NUM_DIGITS  digit nibbles; digit 0 (LSD) = Din[3:0].
- dp_in  input  NUM_DIGITS  decimal point request per digit.
- load  input  1  capture Din/dp_in for display.
- lz_en  input  1  leading-zero suppression enable.
- blink_mask  input  NUM_DIGITS  1 = digit blinks.
- a, b, c, d, e, f, g  output  1 each  segment drives.
- dp  output  1  decimal point drive.
- an  output  NUM_DIGITS  digit anode enables, one-hot when lit.
- frame_tick  output  1  one-cycle pulse when the scan wraps from the last digit to digit 0.

Behaviour:
- Reset (rst=1 at a clk edge):
  - scan counter=0, digit index=0, frame counter=0, blink phase=0;
  - pending and shadow registers = 0, pending_valid=0;
  - all segment, dp and an outputs at their inactive level: SEG/AN_ACTIVE_LOW=1 gives all 1s;
  - frame_tick=0.
  - Reset mid-scan aborts immediately; no partial frame completes.
- Scan counter:
  - counts 0..SCAN_DIV-1;
  - at SCAN_DIV-1 it wraps to 0 and the digit index advances;
  - index NUM_DIGITS-1 wraps to 0 and frame_tick pulses on that same edge.
- Outputs are registered. an and segments reflect the new index on the clk edge after the index changes, so the latency is exactly 1 cycle, and an and segments always change on the same edge.
- Load:
  - load=1 captures Din/dp_in into pending and sets pending_valid.
  - At the frame_tick edge, pending is copied into shadow and pending_valid is cleared.
  - load=1 on the frame_tick edge itself: Din goes directly to shadow.
  - Repeated loads within one frame: only the last is shown.
  - Display always decodes shadow.
- Decode, with logical active-high segments (inverted at the pins when SEG_ACTIVE_LOW=1):
  - 0 abcdef
  - 1 bc
  - 2 abdeg
  - 3 abcdg
  - 4 bcfg
  - 5 acdfg
  - 6 acdefg
  - 7 abc
  - 8 abcdefg
  - 9 abcdfg
  - A abcefg
  - b cdefg
  - C adef
  - d bcdeg
  - E adefg
  - F aefg
- Leading-zero suppression (lz_en=1):
  - working down from digit NUM_DIGITS-1, zero digits are blanked until the first nonzero digit;
  - digit 0 is never suppressed;
  - a suppressed digit keeps its an asserted with segments off; its dp still follows dp_in.
- Blink:
  - frame counter counts frame_ticks 0..BLINK_FRAMES-1; at wrap the blink phase toggles.
  - Phase=1: digits with blink_mask set have segments, dp and an all inactive.
  - blink_mask changes take effect on the next digit slot.
- NUM_DIGITS=1: index stays 0 and frame_tick pulses every SCAN_DIV cycles.

Test Plan:
- Shared sim settings: NUM_DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2, both ACTIVE_LOW=1.
- Reset check: hold rst 3 cycles -> an=4'b1111, {a..g}=7'b1111111, dp=1, frame_tick=0; release -> an=4'b1110 one cycle later.
- Scan/decode: load Din=16'h1234, wait one frame -> an steps 1110, 1101, 1011, 0111, each held 4 cycles. Segments {a..g}:
  - digit0 = 4 -> 1001100
  - digit1 = 3 -> 0000110
  - digit2 = 2 -> 0010010
  - digit3 = 1 -> 1001111
  - frame_tick pulses every 16 cycles.
- Frame-sync load: load Din=16'h0000 mid-frame after 16'h8888 -> remaining slots of that frame still show 8 (0000000); the next frame shows 0 (0000001). Load asserted on the frame_tick edge -> new value is shown in the very next slot.
- Leading zeros: Din=16'h0050, lz_en=1 -> digits 3 and 2 blank ({a..g}=1111111, an still low); digit1 shows 5 (0100100); digit0 shows 0 (0000001). Din=16'h0000 -> only digit0 lit.
- Blink: blink_mask=4'b0001 -> digit0 lit for 2 frames, then fully inactive (an bit=1) for 2 frames; other digits unaffected.
- Reset mid-operation: assert rst while index=2 with blink phase=1 -> the next cycle all outputs are inactive and index/phase restart at 0.
